// File: rtl/acorn_prng_seq_ctrl.sv
// ---------------------------------------------------------------------------
// acorn_prng_seq_ctrl
//
// Sequencer for the acorn_prng core. On start it latches a seed from the
// GPIO pads, the LA1 bus or their XOR, and holds the core in reset for a
// fixed number of cycles. It then pulses the load strobe and discards a
// warm-up period. After that it streams PRNG words through a 1-deep
// valid/ready sample register until the sample budget is used up.
//
// Ports
//   clk           clock (wb_clk_i domain)
//   reset         asynchronous, active-low reset
//   start         1-cycle pulse; starts a run when idle or done
//   abort         level; returns the sequencer to IDLE on the next edge
//   src_sel       seed source: 00 gpio, 01 la, 10 gpio^la, 11 gpio
//   gpio_seed     seed from the IO pads
//   la_seed       seed from LA1
//   budget        samples per run, 0 = unlimited
//   prng_out      current PRNG word from the core
//   prng_reset    active-high reset to the core
//   prng_load     load strobe to the core
//   prng_select   seed-select to the core (fixed to the direct seed port)
//   prng_seed     seed latched at start
//   sample_data   captured PRNG word
//   sample_valid  sample_data holds a word the consumer has not taken yet
//   sample_ready  consumer accepts the word when valid && ready
//   sample_count  samples accepted this run (saturates at all-ones)
//   busy          a run is in progress
//   done          the run has finished (budget reached)
// ---------------------------------------------------------------------------
module acorn_prng_seq_ctrl #(
    parameter int WIDTH   = 12,
    parameter int RST_CYC = 4,
    parameter int WARMUP  = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       src_sel,
    input  logic [WIDTH-1:0] gpio_seed,
    input  logic [WIDTH-1:0] la_seed,
    input  logic [CNT_W-1:0] budget,
    input  logic [WIDTH-1:0] prng_out,
    output logic             prng_reset,
    output logic             prng_load,
    output logic [1:0]       prng_select,
    output logic [WIDTH-1:0] prng_seed,
    output logic [WIDTH-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic [CNT_W-1:0] sample_count,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RST  = 3'd1;
    localparam logic [2:0] ST_LOAD = 3'd2;
    localparam logic [2:0] ST_WARM = 3'd3;
    localparam logic [2:0] ST_RUN  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // A single down-counter times both the reset hold and the warm-up.
    localparam int MAX_CYC = (RST_CYC > WARMUP) ? RST_CYC : WARMUP;
    localparam int TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] RST_LD  = TW'(RST_CYC - 1);
    localparam logic [TW-1:0] WARM_LD = TW'(WARMUP - 1);

    logic [2:0]       state_reg;
    logic [TW-1:0]    timer_reg;
    logic [WIDTH-1:0] seed_reg;
    logic [CNT_W-1:0] budget_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    logic [WIDTH-1:0] seed_next;
    logic [CNT_W-1:0] count_inc;
    logic             accept;

    // Seed source select; the reserved code falls back to the pads.
    always_comb begin
        seed_next = gpio_seed;
        case (src_sel)
            2'b01:   seed_next = la_seed;
            2'b10:   seed_next = gpio_seed ^ la_seed;
            default: seed_next = gpio_seed;
        endcase
    end

    assign count_inc = (count_reg == {CNT_W{1'b1}}) ? count_reg : count_reg + 1'b1;
    assign accept    = valid_reg && sample_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= ST_IDLE;
            timer_reg  <= '0;
            seed_reg   <= '0;
            budget_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
        end else if (abort) begin
            // The count of the aborted run stays visible until the next start.
            state_reg <= ST_IDLE;
            valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        seed_reg   <= seed_next;
                        budget_reg <= budget;
                        count_reg  <= '0;
                        timer_reg  <= RST_LD;
                        state_reg  <= ST_RST;
                    end
                end
                ST_RST: begin
                    if (timer_reg == '0) begin
                        state_reg <= ST_LOAD;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                ST_LOAD: begin
                    timer_reg <= WARM_LD;
                    state_reg <= ST_WARM;
                end
                ST_WARM: begin
                    if (timer_reg == '0) begin
                        state_reg <= ST_RUN;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        count_reg <= count_inc;
                        if ((budget_reg != '0) && (count_inc == budget_reg)) begin
                            // Budget met: stop without capturing another word.
                            valid_reg <= 1'b0;
                            state_reg <= ST_DONE;
                        end else begin
                            data_reg  <= prng_out;
                            valid_reg <= 1'b1;
                        end
                    end else if (!valid_reg) begin
                        data_reg  <= prng_out;
                        valid_reg <= 1'b1;
                    end
                    // Stall: the register holds and the words the core
                    // produces in the meantime are dropped.
                end
                default: begin
                    state_reg <= ST_IDLE;
                    valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign prng_reset   = (state_reg == ST_IDLE) || (state_reg == ST_RST);
    assign prng_load    = (state_reg == ST_LOAD);
    assign prng_select  = 2'b11;
    assign prng_seed    = seed_reg;
    assign sample_data  = data_reg;
    assign sample_valid = valid_reg;
    assign sample_count = count_reg;
    assign done         = (state_reg == ST_DONE);
    assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_DONE);

endmodule

// File: tb/tb_acorn_prng_seq_ctrl.sv
module tb_acorn_prng_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  src_sel = 2'b00;
    logic [11:0] gpio_seed = '0;
    logic [11:0] la_seed = '0;
    logic [15:0] budget = '0;
    logic [11:0] prng_out = 12'h001;
    logic        prng_reset;
    logic        prng_load;
    logic [1:0]  prng_select;
    logic [11:0] prng_seed;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready = 1'b0;
    logic [15:0] sample_count;
    logic        busy;
    logic        done;

    int n_vec  = 0;
    int n_miss = 0;

    acorn_prng_seq_ctrl dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .abort        (abort),
        .src_sel      (src_sel),
        .gpio_seed    (gpio_seed),
        .la_seed      (la_seed),
        .budget       (budget),
        .prng_out     (prng_out),
        .prng_reset   (prng_reset),
        .prng_load    (prng_load),
        .prng_select  (prng_select),
        .prng_seed    (prng_seed),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_count (sample_count),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Stand-in for the core: a word that changes every cycle, updated on the
    // falling edge so it is stable at the capturing rising edge.
    always @(negedge clk) prng_out <= prng_out + 12'h035;

    typedef struct {
        logic [1:0]  src_sel;
        logic [11:0] gpio;
        logic [11:0] la;
        logic [15:0] budget;
        logic [11:0] exp_seed;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full run with ready held high; checks the sequencing and the result.
    task automatic run_vec(input int idx, input vec_t v);
        int k = 0;
        int first_valid = -1;
        int rst_cyc = 0;
        int load_cyc = 0;
        bit seen_done = 0;
        logic [11:0] load_seed = '0;
        logic [15:0] cnt_end;
        src_sel      = v.src_sel;
        gpio_seed    = v.gpio;
        la_seed      = v.la;
        budget       = v.budget;
        sample_ready = 1'b1;
        start        = 1'b1;
        step();
        start     = 1'b0;
        // Change the inputs after the start edge; the latched values must hold.
        src_sel   = 2'b01;
        gpio_seed = ~v.gpio;
        la_seed   = ~v.la;
        budget    = 16'd0;
        while (!seen_done && k < 200) begin
            if (prng_reset && busy) rst_cyc++;
            if (prng_load) begin
                load_cyc++;
                load_seed = prng_seed;
            end
            if (sample_valid) begin
                if (first_valid < 0) first_valid = k;
                check("run_data", {20'd0, sample_data}, {20'd0, prng_out});
            end
            if (done) seen_done = 1;
            else begin
                step();
                k++;
            end
        end
        check("run_done_seen", {31'd0, seen_done}, 32'd1);
        check("run_rst_cycles", rst_cyc, 4);
        check("run_load_cycles", load_cyc, 1);
        check("run_load_seed", {20'd0, load_seed}, {20'd0, v.exp_seed});
        check("run_first_valid", first_valid, 22);
        check("run_done_cycle", k, 22 + int'(v.budget));
        check("run_count", {16'd0, sample_count}, {16'd0, v.budget});
        check("run_valid_done", {31'd0, sample_valid}, 32'd0);
        check("run_prng_reset_done", {31'd0, prng_reset}, 32'd0);
        check("run_busy_done", {31'd0, busy}, 32'd0);
        check("run_select", {30'd0, prng_select}, 32'd3);
        cnt_end = sample_count;
        repeat (3) step();
        check("run_done_hold", {31'd0, done}, 32'd1);
        check("run_count_hold", {16'd0, sample_count}, {16'd0, cnt_end});
        $display("vec %0d: src_sel=%b seed=%h budget=%0d first_valid=%0d count=%0d",
                 idx, v.src_sel, load_seed, v.budget, first_valid, sample_count);
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!sample_valid && k < 100) begin
            step();
            k++;
        end
        check(name, {31'd0, sample_valid}, 32'd1);
    endtask

    initial begin
        logic [11:0] d0;
        bit          saw_done;

        vecs[0] = '{src_sel: 2'b01, gpio: 12'h111, la: 12'hA5C, budget: 16'd3, exp_seed: 12'hA5C};
        vecs[1] = '{src_sel: 2'b10, gpio: 12'h0F0, la: 12'h0FF, budget: 16'd2, exp_seed: 12'h00F};
        vecs[2] = '{src_sel: 2'b11, gpio: 12'h123, la: 12'h456, budget: 16'd1, exp_seed: 12'h123};
        vecs[3] = '{src_sel: 2'b00, gpio: 12'h7E1, la: 12'h3C3, budget: 16'd4, exp_seed: 12'h7E1};

        // Reset values
        #12;
        check("rst_prng_reset", {31'd0, prng_reset}, 32'd1);
        check("rst_prng_select", {30'd0, prng_select}, 32'd3);
        check("rst_prng_load", {31'd0, prng_load}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_count", {16'd0, sample_count}, 32'd0);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        rst_n = 1'b1;
        step();

        // Table-driven runs: the first from IDLE, the rest restart from DONE.
        for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

        // Stall: data frozen while ready is low, then advances on accept.
        budget = 16'd5;
        sample_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("stall_valid_wait");
        d0 = sample_data;
        repeat (10) step();
        check("stall_data", {20'd0, sample_data}, {20'd0, d0});
        check("stall_count", {16'd0, sample_count}, 32'd0);
        check("stall_valid", {31'd0, sample_valid}, 32'd1);
        sample_ready = 1'b1;
        step();
        check("stall_release_count", {16'd0, sample_count}, 32'd1);
        check("stall_release_data", {20'd0, sample_data}, {20'd0, prng_out});
        $display("stall: held %h, released to %h, count=%0d", d0, sample_data, sample_count);

        // Abort in RUN with valid high
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_run_busy", {31'd0, busy}, 32'd0);
        check("abort_run_valid", {31'd0, sample_valid}, 32'd0);
        check("abort_run_prng_reset", {31'd0, prng_reset}, 32'd1);
        check("abort_run_count_kept", {16'd0, sample_count}, 32'd1);
        $display("abort in RUN: busy=%0d valid=%0d count=%0d", busy, sample_valid, sample_count);

        // Abort in WARM
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        check("warm_busy_before", {31'd0, busy}, 32'd1);
        check("warm_prng_reset_before", {31'd0, prng_reset}, 32'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_warm_busy", {31'd0, busy}, 32'd0);
        check("abort_warm_prng_reset", {31'd0, prng_reset}, 32'd1);
        check("abort_warm_count", {16'd0, sample_count}, 32'd0);
        $display("abort in WARM: busy=%0d prng_reset=%0d", busy, prng_reset);

        // start and abort together: stays IDLE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        check("start_abort_busy", {31'd0, busy}, 32'd0);
        check("start_abort_prng_reset", {31'd0, prng_reset}, 32'd1);
        $display("start+abort: busy=%0d", busy);

        // Reset mid-RUN, then a full run again
        budget = 16'd0;
        sample_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("mid_rst_valid_wait");
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_prng_reset", {31'd0, prng_reset}, 32'd1);
        check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_count", {16'd0, sample_count}, 32'd0);
        check("mid_rst_data", {20'd0, sample_data}, 32'd0);
        check("mid_rst_seed", {20'd0, prng_seed}, 32'd0);
        $display("reset mid-run: prng_reset=%0d valid=%0d busy=%0d", prng_reset, sample_valid, busy);
        step();
        rst_n = 1'b1;
        step();
        run_vec(4, vecs[0]);

        // Unlimited budget: never DONE, count saturates
        budget = 16'd0;
        sample_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 70000; i++) begin
            step();
            if (done) saw_done = 1;
        end
        check("unl_no_done", {31'd0, saw_done}, 32'd0);
        check("unl_busy", {31'd0, busy}, 32'd1);
        check("unl_count_sat", {16'd0, sample_count}, 32'h0000FFFF);
        check("unl_valid", {31'd0, sample_valid}, 32'd1);
        $display("unlimited: count=%h done_seen=%0d", sample_count, saw_done);
        abort = 1'b1;
        step();
        abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
